// File: rtl/sr_latch_pkg.sv
// Shared types and helpers for the set/clear latch bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sr_latch_pkg;

  // Resolution used when set and clear arrive on the same channel in the same cycle
  typedef enum logic [1:0] {
    SET_WINS = 2'd0,
    CLR_WINS = 2'd1,
    TOGGLE   = 2'd2,
    HOLD     = 2'd3
  } prio_mode_t;

  // Hold counter width; never below one bit so HOLD_CYCLES=0 still builds
  function automatic int hold_width(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_latch_cell.sv
// One latch channel: state bit, minimum-hold counter, optional set edge detector.
// Latency: inputs sampled at a rising edge update state at that same edge.
// Backpressure: none; every cycle is evaluated.
// SR_EDGE_SET_EN: when defined, set acts only on a 0->1 transition of set_in.
module sr_latch_cell
  import sr_latch_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_in,
  input  logic       clr_in,
  input  logic [1:0] prio_mode,
  output logic       state
);

  localparam int HOLD_W = hold_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] ONE    = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_nxt;
  logic              state_nxt;
  logic              hold;
  logic              set_eff;
  prio_mode_t        mode;

  assign hold = (cnt != '0);
  assign mode = prio_mode_t'(prio_mode);

`ifdef SR_EDGE_SET_EN
  logic set_d;

  // Remember last cycle's set request; cleared by reset so a level held
  // through reset still yields one set right after release
  always_ff @(posedge clk) begin
    if (reset) set_d <= 1'b0;
    else       set_d <= set_in;
  end

  assign set_eff = set_in & ~set_d;
`else
  assign set_eff = set_in;
`endif

  // Next latch state and hold counter; reload beats the default decrement
  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold ? (cnt - ONE) : cnt;
    case ({set_eff, clr_in})
      2'b10: begin
        state_nxt = 1'b1;
        cnt_nxt   = RELOAD;
      end
      2'b01: begin
        if (!hold) state_nxt = 1'b0;
      end
      2'b11: begin
        case (mode)
          SET_WINS: begin
            state_nxt = 1'b1;
            cnt_nxt   = RELOAD;
          end
          CLR_WINS: begin
            if (!hold) state_nxt = 1'b0;
            cnt_nxt = RELOAD;
          end
          TOGGLE: begin
            state_nxt = ~state;
            if (!state) cnt_nxt = RELOAD;
          end
          default: begin
            // HOLD: freeze both the bit and the counter
            cnt_nxt = cnt;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Register latch bit and hold counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sr_latch_bank.sv
// N-channel registered set/clear latch bank with selectable priority and a snapshot port.
// Latency: state_out updates at the edge that samples set/clr; snapshot captured in one cycle.
// Backpressure: snap_valid/snap_data hold while snap_ready=0; requests then are dropped (snap_drop).
// SR_EDGE_SET_EN: when defined, each channel's set is rising-edge triggered instead of level.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] set_in,
  input  logic [N_CH-1:0] clr_in,
  input  logic [1:0]      prio_mode,
  output logic [N_CH-1:0] state_out,
  input  logic            snap_req,
  output logic            snap_valid,
  input  logic            snap_ready,
  output logic [N_CH-1:0] snap_data,
  output logic            snap_drop
);

  logic accept;
  logic capture;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sr_latch_cell #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .set_in   (set_in[i]),
      .clr_in   (clr_in[i]),
      .prio_mode(prio_mode),
      .state    (state_out[i])
    );
  end

  // A new capture may land in the same cycle the old one is consumed
  assign accept  = snap_valid & snap_ready;
  assign capture = snap_req & (~snap_valid | accept);

  // Snapshot register: capture pre-update state, hold while unaccepted, flag dropped requests
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
      snap_drop  <= 1'b0;
    end else begin
      snap_drop <= snap_req & snap_valid & ~snap_ready;
      if (capture) begin
        snap_valid <= 1'b1;
        snap_data  <= state_out;
      end else if (accept) begin
        snap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] set_in;
  logic [7:0] clr_in;
  logic [1:0] prio_mode;
  logic [7:0] state_out;
  logic       snap_req;
  logic       snap_valid;
  logic       snap_ready;
  logic [7:0] snap_data;
  logic       snap_drop;

  int checks = 0;
  int errors = 0;

  sr_latch_bank #(.N_CH(8), .HOLD_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .set_in    (set_in),
    .clr_in    (clr_in),
    .prio_mode (prio_mode),
    .state_out (state_out),
    .snap_req  (snap_req),
    .snap_valid(snap_valid),
    .snap_ready(snap_ready),
    .snap_data (snap_data),
    .snap_drop (snap_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; set_in = 8'hFF; clr_in = 8'h00; prio_mode = 2'd0;
    snap_req = 1'b0; snap_ready = 1'b0;

    // 1: reset for 3 cycles with set held high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_state", state_out, 8'h00);
    end
    chk("rst_snap_valid", {7'b0, snap_valid}, 8'h00);
    chk("rst_snap_data", snap_data, 8'h00);
    chk("rst_snap_drop", {7'b0, snap_drop}, 8'h00);
    reset = 1'b0;
    tick();
    chk("post_rst_set", state_out, 8'hFF);
    tick();
    chk("post_rst_held", state_out, 8'hFF);

    // clear all once hold expires: 4 held-off edges, cleared on the 5th
    set_in = 8'h00; clr_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_blocked", state_out, 8'hFF);
    end
    tick();
    chk("clr_done", state_out, 8'h00);

    // 2: ch0 set one cycle, then clear held
    clr_in = 8'h00; set_in = 8'h01;
    tick();
    chk("hold_set", state_out, 8'h01);
    set_in = 8'h00; clr_in = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("hold_active", state_out, 8'h01);
    end
    tick();
    chk("hold_released", state_out, 8'h00);

    // 3: coincident set & clear under each priority mode (hold expired)
    prio_mode = 2'd0; set_in = 8'h01; clr_in = 8'h01;
    tick();
    chk("set_wins", state_out, 8'h01);
    set_in = 8'h00; clr_in = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    prio_mode = 2'd1; set_in = 8'h01; clr_in = 8'h01;
    tick();
    chk("clr_wins", state_out, 8'h00);
    prio_mode = 2'd2;
    tick();
    chk("toggle_1", state_out, 8'h01);
    tick();
    chk("toggle_2", state_out, 8'h00);
    tick();
    chk("toggle_3", state_out, 8'h01);
    prio_mode = 2'd3;
    tick();
    chk("hold_mode_1", state_out, 8'h01);
    tick();
    chk("hold_mode_2", state_out, 8'h01);
    set_in = 8'h00; clr_in = 8'h00; prio_mode = 2'd0;

    // 4: build state 0xA5 from a clean reset, then snapshot with consumer stalled
    reset = 1'b1;
    tick();
    reset = 1'b0; set_in = 8'hA5;
    tick();
    chk("state_a5", state_out, 8'hA5);
    set_in = 8'h00; snap_req = 1'b1; snap_ready = 1'b0;
    tick();
    chk("snap_valid_a5", {7'b0, snap_valid}, 8'h01);
    chk("snap_data_a5", snap_data, 8'hA5);
    chk("no_drop_first", {7'b0, snap_drop}, 8'h00);
    tick();
    chk("snap_drop_pulse", {7'b0, snap_drop}, 8'h01);
    chk("snap_data_kept", snap_data, 8'hA5);
    snap_req = 1'b0;
    tick();
    chk("snap_drop_cleared", {7'b0, snap_drop}, 8'h00);

    // 5: move state to 0x3C while snapshot is stalled, then capture on accept
    for (int i = 0; i < 4; i++) tick();
    chk("stall_valid", {7'b0, snap_valid}, 8'h01);
    chk("stall_data", snap_data, 8'hA5);
    set_in = 8'h3C; clr_in = 8'hC3;
    tick();
    chk("state_3c", state_out, 8'h3C);
    set_in = 8'h00; clr_in = 8'h00; snap_req = 1'b1; snap_ready = 1'b1;
    tick();
    chk("b2b_valid", {7'b0, snap_valid}, 8'h01);
    chk("b2b_data", snap_data, 8'h3C);
    snap_req = 1'b0;
    tick();
    chk("accept_clears_valid", {7'b0, snap_valid}, 8'h00);

    // 6: reset with snapshot pending and counters loaded
    snap_req = 1'b1; snap_ready = 1'b0; set_in = 8'hFF;
    tick();
    chk("pre_rst_valid", {7'b0, snap_valid}, 8'h01);
    chk("pre_rst_state", state_out, 8'hFF);
    reset = 1'b1; snap_req = 1'b0;
    tick();
    chk("mid_rst_valid", {7'b0, snap_valid}, 8'h00);
    chk("mid_rst_state", state_out, 8'h00);
    chk("mid_rst_data", snap_data, 8'h00);
    set_in = 8'h00; reset = 1'b0; clr_in = 8'hFF;
    tick();
    chk("after_rst_clr", state_out, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
